// File: rtl/csa_mult_pipe.sv
// Pipelined carry-save array multiplier (unsigned / Baugh-Wooley signed) with
// valid/ready handshake, a pass-through tag and a registered carry-propagate output stage.
module csa_mult_pipe #(
    parameter int WIDTH          = 6,
    parameter int ROWS_PER_STAGE = 2,
    parameter int TAG_W          = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_signed,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_prod,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 out_signed
);

    localparam int S  = (WIDTH + ROWS_PER_STAGE - 1) / ROWS_PER_STAGE;
    localparam int PW = 2 * WIDTH;
    localparam logic [PW-1:0]    BW_K = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));
    localparam logic [WIDTH-1:0] MSB  = WIDTH'(1) << (WIDTH - 1);

    // Index 0 is the operand capture register; index k+1 holds the result of row group k.
    logic              v_q   [0:S];
    logic              sg_q  [0:S];
    logic [TAG_W-1:0]  tag_q [0:S];
    logic [WIDTH-1:0]  a_q   [0:S];
    logic [WIDTH-1:0]  b_q   [0:S];
    logic [PW-1:0]     s_q   [0:S];
    logic [PW-1:0]     c_q   [0:S];

    logic [PW-1:0]     red_s [0:S-1];
    logic [PW-1:0]     red_c [0:S-1];

    logic              adv;

    assign adv      = !(out_valid && !out_ready);
    assign in_ready = adv;

    // Each group folds its rows into the redundant pair with one 3:2 compressor per row.
    // Signed rows flip the MSB column, except the last row which flips all but its MSB.
    always_comb begin
        logic [PW-1:0]    s;
        logic [PW-1:0]    c;
        logic [PW-1:0]    r;
        logic [PW-1:0]    m;
        logic [WIDTH-1:0] row;
        s   = '0;
        c   = '0;
        r   = '0;
        m   = '0;
        row = '0;
        for (int unsigned k = 0; k < S; k++) begin
            s = s_q[k];
            c = c_q[k];
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (i >= k * ROWS_PER_STAGE && i < (k + 1) * ROWS_PER_STAGE) begin
                    row = a_q[k] & {WIDTH{b_q[k][i]}};
                    if (sg_q[k]) begin
                        row = row ^ ((i == WIDTH - 1) ? ~MSB : MSB);
                    end
                    r = PW'(row) << i;
                    m = (s & c) | (s & r) | (c & r);
                    s = s ^ c ^ r;
                    c = m << 1;
                end
            end
            red_s[k] = s;
            red_c[k] = c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k <= S; k++) begin
                v_q[k]   <= 1'b0;
                sg_q[k]  <= 1'b0;
                tag_q[k] <= '0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                s_q[k]   <= '0;
                c_q[k]   <= '0;
            end
            out_valid  <= 1'b0;
            out_prod   <= '0;
            out_tag    <= '0;
            out_signed <= 1'b0;
        end else if (adv) begin
            v_q[0]   <= in_valid;
            sg_q[0]  <= in_signed;
            tag_q[0] <= in_tag;
            a_q[0]   <= in_a;
            b_q[0]   <= in_b;
            s_q[0]   <= in_signed ? BW_K : '0;
            c_q[0]   <= '0;
            for (int unsigned k = 0; k < S; k++) begin
                v_q[k+1]   <= v_q[k];
                sg_q[k+1]  <= sg_q[k];
                tag_q[k+1] <= tag_q[k];
                a_q[k+1]   <= a_q[k];
                b_q[k+1]   <= b_q[k];
                s_q[k+1]   <= red_s[k];
                c_q[k+1]   <= red_c[k];
            end
            out_valid <= v_q[S];
            if (v_q[S]) begin
                out_prod   <= s_q[S] + c_q[S];
                out_tag    <= tag_q[S];
                out_signed <= sg_q[S];
            end
        end
    end

endmodule

// File: tb/tb_csa_mult_pipe.sv
// Directed and model-checked bench for csa_mult_pipe at three parameter points.
module tb_csa_mult_pipe;

    typedef struct packed {
        logic [3:0]  tag;
        logic        sg;
        logic [63:0] prod;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // WIDTH=6, ROWS_PER_STAGE=2 (default, L=4)
    logic v6 = 1'b0, r6, s6 = 1'b0, ov6, or6 = 1'b1, os6;
    logic [5:0] a6 = '0, b6 = '0;
    logic [3:0] t6 = '0, ot6;
    logic [11:0] p6;
    // WIDTH=8, ROWS_PER_STAGE=3 (L=4)
    logic v8 = 1'b0, r8, s8 = 1'b0, ov8, or8 = 1'b1, os8;
    logic [7:0] a8 = '0, b8 = '0;
    logic [3:0] t8 = '0, ot8;
    logic [15:0] p8;
    // WIDTH=5, ROWS_PER_STAGE=1 (L=6)
    logic v5 = 1'b0, r5, s5 = 1'b0, ov5, or5 = 1'b1, os5;
    logic [4:0] a5 = '0, b5 = '0;
    logic [3:0] t5 = '0, ot5;
    logic [9:0] p5;

    csa_mult_pipe u_w6 (
        .clk(clk), .rst_n(rst_n), .in_valid(v6), .in_ready(r6), .in_a(a6), .in_b(b6),
        .in_signed(s6), .in_tag(t6), .out_valid(ov6), .out_ready(or6), .out_prod(p6),
        .out_tag(ot6), .out_signed(os6));

    csa_mult_pipe #(.WIDTH(8), .ROWS_PER_STAGE(3), .TAG_W(4)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8), .in_a(a8), .in_b(b8),
        .in_signed(s8), .in_tag(t8), .out_valid(ov8), .out_ready(or8), .out_prod(p8),
        .out_tag(ot8), .out_signed(os8));

    csa_mult_pipe #(.WIDTH(5), .ROWS_PER_STAGE(1), .TAG_W(4)) u_w5 (
        .clk(clk), .rst_n(rst_n), .in_valid(v5), .in_ready(r5), .in_a(a5), .in_b(b5),
        .in_signed(s5), .in_tag(t5), .out_valid(ov5), .out_ready(or5), .out_prod(p5),
        .out_tag(ot5), .out_signed(os5));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Plain integer reference product, truncated to 2*w bits.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic sg, input int w);
        longint av, bv, p;
        av = longint'(a);
        bv = longint'(b);
        if (sg && a[w-1]) av = av - (longint'(1) << w);
        if (sg && b[w-1]) bv = bv - (longint'(1) << w);
        p = av * bv;
        return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    exp_t q6[$], q8[$], q5[$];
    exp_t e6, e8, e5;
    int acc6 = 0, cons6 = 0, run6 = 0, maxrun6 = 0;
    int acc8 = 0, cons8 = 0, acc5 = 0, cons5 = 0;

    // Scoreboards: record accepted beats, compare every consumed result in order.
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            q6.delete();
            run6 = 0;
        end else begin
            if (ov6 && or6) begin
                cons6++;
                run6++;
                if (run6 > maxrun6) maxrun6 = run6;
                if (q6.size() == 0) chk("w6_spurious_out", 64'(ov6), 64'd0);
                else begin
                    e6 = q6.pop_front();
                    chk("w6_prod", 64'(p6), e6.prod);
                    chk("w6_tag", 64'(ot6), 64'(e6.tag));
                    chk("w6_signed", 64'(os6), 64'(e6.sg));
                end
            end else run6 = 0;
            if (v6 && r6) begin
                acc6++;
                e6.tag = t6; e6.sg = s6; e6.prod = ref_mul(32'(a6), 32'(b6), s6, 6);
                q6.push_back(e6);
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (!rst_n) q8.delete();
        else begin
            if (ov8 && or8) begin
                cons8++;
                if (q8.size() == 0) chk("w8_spurious_out", 64'(ov8), 64'd0);
                else begin
                    e8 = q8.pop_front();
                    chk("w8_prod", 64'(p8), e8.prod);
                    chk("w8_tag", 64'(ot8), 64'(e8.tag));
                    chk("w8_signed", 64'(os8), 64'(e8.sg));
                end
            end
            if (v8 && r8) begin
                acc8++;
                e8.tag = t8; e8.sg = s8; e8.prod = ref_mul(32'(a8), 32'(b8), s8, 8);
                q8.push_back(e8);
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (!rst_n) q5.delete();
        else begin
            if (ov5 && or5) begin
                cons5++;
                if (q5.size() == 0) chk("w5_spurious_out", 64'(ov5), 64'd0);
                else begin
                    e5 = q5.pop_front();
                    chk("w5_prod", 64'(p5), e5.prod);
                    chk("w5_tag", 64'(ot5), 64'(e5.tag));
                    chk("w5_signed", 64'(os5), 64'(e5.sg));
                end
            end
            if (v5 && r5) begin
                acc5++;
                e5.tag = t5; e5.sg = s5; e5.prod = ref_mul(32'(a5), 32'(b5), s5, 5);
                q5.push_back(e5);
            end
        end
    end

    task automatic run_one(input logic [5:0] a, input logic [5:0] b, input logic sg,
                           input logic [3:0] t, input logic [11:0] exp);
        int n;
        @(negedge clk);
        v6 = 1'b1; a6 = a; b6 = b; s6 = sg; t6 = t;
        @(negedge clk);
        v6 = 1'b0;
        n = 0;
        while (!ov6 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("w6_latency", 64'(n), 64'd4);
        chk("w6_directed_prod", 64'(p6), 64'(exp));
        chk("w6_directed_tag", 64'(ot6), 64'(t));
        chk("w6_directed_signed", 64'(os6), 64'(sg));
    endtask

    initial begin
        int n, idx, cyc, stale;
        logic [11:0] hp;
        logic [3:0]  ht;

        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(ov6), 64'd0);
        chk("rst_out_prod", 64'(p6), 64'd0);
        chk("rst_out_tag", 64'(ot6), 64'd0);
        chk("rst_out_signed", 64'(os6), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_in_ready", 64'(r6), 64'd1);

        run_one(6'd63, 6'd63, 1'b0, 4'h5, 12'hF81);
        run_one(6'h20, 6'h20, 1'b1, 4'h6, 12'h400);
        run_one(6'h20, 6'h1F, 1'b1, 4'h7, 12'hC20);
        run_one(6'h3F, 6'h3F, 1'b1, 4'h8, 12'h001);
        run_one(6'h3F, 6'h01, 1'b0, 4'h9, 12'h03F);

        // 16 back-to-back beats with mixed modes
        maxrun6 = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            v6 = 1'b1; a6 = 6'($urandom); b6 = 6'($urandom); s6 = 1'($urandom); t6 = 4'(i);
        end
        @(negedge clk);
        v6 = 1'b0;
        n = 0;
        while (q6.size() != 0 && n < 40) begin @(negedge clk); n++; end
        chk("burst_drained", 64'(q6.size()), 64'd0);
        chk("burst_consecutive", 64'(maxrun6), 64'd16);

        // Downstream stall for three cycles mid-stream
        idx = 0; cyc = 0; hp = '0; ht = '0;
        while (idx < 10 && cyc < 60) begin
            @(negedge clk);
            or6 = !(cyc >= 6 && cyc < 9);
            v6 = 1'b1; a6 = 6'($urandom); b6 = 6'($urandom); s6 = 1'($urandom); t6 = 4'(idx);
            #1;
            chk("stall_in_ready", 64'(r6), 64'(or6));
            if (cyc == 6) begin
                chk("stall_out_valid", 64'(ov6), 64'd1);
                hp = p6; ht = ot6;
            end else if (cyc > 6 && cyc < 9) begin
                chk("stall_hold_prod", 64'(p6), 64'(hp));
                chk("stall_hold_tag", 64'(ot6), 64'(ht));
            end
            if (v6 && r6) idx++;
            cyc++;
        end
        chk("stall_all_sent", 64'(idx), 64'd10);
        @(negedge clk);
        v6 = 1'b0; or6 = 1'b1;
        n = 0;
        while (q6.size() != 0 && n < 40) begin @(negedge clk); n++; end
        chk("stall_drained", 64'(q6.size()), 64'd0);
        chk("stall_no_loss", 64'(cons6), 64'(acc6));

        // Reset with beats in flight
        @(negedge clk); v6 = 1'b1; a6 = 6'h3F; b6 = 6'h02; s6 = 1'b1; t6 = 4'hA;
        @(negedge clk); a6 = 6'h11; b6 = 6'h05; s6 = 1'b0; t6 = 4'hB;
        @(negedge clk); a6 = 6'h2A; b6 = 6'h13; s6 = 1'b1; t6 = 4'hC;
        @(negedge clk); v6 = 1'b0;
        n = 0;
        while (!ov6 && n < 20) begin @(negedge clk); n++; end
        chk("midflight_first_out", 64'(ov6), 64'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(ov6), 64'd0);
        chk("async_rst_prod", 64'(p6), 64'd0);
        chk("async_rst_tag", 64'(ot6), 64'd0);
        chk("async_rst_signed", 64'(os6), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        repeat (10) begin
            @(negedge clk);
            if (ov6) stale++;
        end
        chk("post_rst_no_stale", 64'(stale), 64'd0);
        run_one(6'h05, 6'h3E, 1'b1, 4'h3, 12'hFF6);

        // WIDTH=8, ROWS_PER_STAGE=3
        @(negedge clk); v8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; s8 = 1'b0; t8 = 4'h9;
        @(negedge clk); v8 = 1'b0;
        n = 0;
        while (!ov8 && n < 20) begin @(negedge clk); n++; end
        chk("w8_latency", 64'(n), 64'd4);
        chk("w8_ff_x_ff", 64'(p8), 64'hFE01);

        // WIDTH=5, ROWS_PER_STAGE=1
        @(negedge clk); v5 = 1'b1; a5 = 5'h1F; b5 = 5'h1F; s5 = 1'b0; t5 = 4'h4;
        @(negedge clk); v5 = 1'b0;
        n = 0;
        while (!ov5 && n < 20) begin @(negedge clk); n++; end
        chk("w5_latency", 64'(n), 64'd6);
        chk("w5_1f_x_1f", 64'(p5), 64'h3C1);

        // Exhaustive WIDTH=5 in both modes
        for (int sg = 0; sg < 2; sg++) begin
            for (int a = 0; a < 32; a++) begin
                for (int b = 0; b < 32; b++) begin
                    @(negedge clk);
                    v5 = 1'b1; a5 = 5'(a); b5 = 5'(b); s5 = 1'(sg); t5 = 4'(a + b);
                end
            end
        end
        @(negedge clk); v5 = 1'b0;

        // Random WIDTH=8 stream with random downstream back-pressure
        idx = 0; cyc = 0;
        while (idx < 200 && cyc < 3000) begin
            @(negedge clk);
            or8 = ($urandom_range(0, 3) != 0);
            v8 = ($urandom_range(0, 3) != 0);
            a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom); t8 = 4'(idx);
            #1;
            if (v8 && r8) idx++;
            cyc++;
        end
        @(negedge clk); v8 = 1'b0; or8 = 1'b1;

        n = 0;
        while ((q5.size() != 0 || q8.size() != 0) && n < 60) begin @(negedge clk); n++; end
        chk("w5_drained", 64'(q5.size()), 64'd0);
        chk("w8_drained", 64'(q8.size()), 64'd0);
        chk("w5_count", 64'(cons5), 64'(acc5));
        chk("w5_exhaustive_beats", 64'(acc5), 64'd2049);
        chk("w8_count", 64'(cons8), 64'(acc8));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
